// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter: shares one RAM port between m0 (priority) and m1 (starvation guard + lockable bursts)
module ram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int TYPE_WIDTH = 3,
  parameter int MAX_WAIT   = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [TYPE_WIDTH-1:0] m0_type,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [TYPE_WIDTH-1:0] m1_type,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wen,
  output logic [TYPE_WIDTH-1:0] ram_type,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic {ARB, BURST} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic rv0_q, rv0_d, rv1_q, rv1_d;
  logic gnt0, gnt1;
  // grant decision, burst tracking, starvation counter and read-owner capture
  always_comb begin
    state_d = state_q;
    burst_cnt_d = burst_cnt_q;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ARB) begin
      gnt1 = m1_req && (!m0_req || wait_cnt_q == WW'(MAX_WAIT));
      gnt0 = m0_req && !gnt1;
      if (gnt1 && m1_lock && BURST_MAX > 1) begin
        state_d = BURST;
        burst_cnt_d = BW'(1);
      end
    end else begin
      gnt1 = m1_req;
      burst_cnt_d = gnt1 ? burst_cnt_q + BW'(1) : burst_cnt_q;
      if (!m1_lock || !m1_req || burst_cnt_d == BW'(BURST_MAX)) begin
        state_d = ARB;
        burst_cnt_d = '0;
      end
    end
    gnt0 = gnt0 && !reset;
    gnt1 = gnt1 && !reset;
    wait_cnt_d = (gnt1 || !m1_req) ? '0 : (wait_cnt_q == WW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WW'(1);
    rv0_d = gnt0 && !m0_we;
    rv1_d = gnt1 && !m1_we;
  end
  // state registers; reset drops any in-flight read and abandons a burst
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      wait_cnt_q <= '0;
      burst_cnt_q <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rv0_q <= rv0_d;
      rv1_q <= rv1_d;
    end
  end
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign ram_addr  = gnt0 ? m0_addr  : gnt1 ? m1_addr  : '0;
  assign ram_type  = gnt0 ? m0_type  : gnt1 ? m1_type  : '0;
  assign ram_wdata = gnt0 ? m0_wdata : gnt1 ? m1_wdata : '0;
  assign ram_wen   = gnt0 ? m0_we    : gnt1 && m1_we;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? ram_rdata : '0;
  assign m1_rdata  = rv1_q ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// tb_ram_arbiter: table-driven vectors plus burst and reset sequences for ram_arbiter
module tb_ram_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [13:0] m0_addr = 0, m1_addr = 0;
  logic [2:0] m0_type = 3'd2, m1_type = 3'd5;
  logic [31:0] m0_wdata = 32'hA0A0A0A0, m1_wdata = 32'hB1B1B1B1;
  logic [31:0] ram_rdata = 0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_wen;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata;
  logic [13:0] ram_addr;
  logic [2:0] ram_type;
  int total = 0, bad = 0;

  ram_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_type(m0_type), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_type(m1_type), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_type(ram_type), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic m0_req, m0_we; logic [13:0] m0_addr;
    logic m1_req, m1_we; logic [13:0] m1_addr;
    logic [31:0] rdata;
    logic g0, g1, v0, v1; logic [31:0] d0, d1; logic [13:0] ra; logic wen;
  } vec_t;
  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r0, input logic lk, input logic r1, input logic e0, input logic e1, input string nm);
    @(negedge clock);
    m0_req = r0; m1_lock = lk; m1_req = r1;
    #1;
    chk({nm, " m0_gnt"}, 32'(m0_gnt), 32'(e0));
    chk({nm, " m1_gnt"}, 32'(m1_gnt), 32'(e1));
    chk({nm, " ram_addr"}, 32'(ram_addr), e0 ? 32'(m0_addr) : e1 ? 32'(m1_addr) : 32'd0);
    chk({nm, " ram_wen"}, 32'(ram_wen), e0 ? 32'(m0_we) : e1 ? 32'(m1_we) : 32'd0);
    chk({nm, " ram_wdata"}, ram_wdata, e0 ? m0_wdata : e1 ? m1_wdata : 32'd0);
  endtask

  initial begin
    tbl[0]  = '{0,0,0,      0,0,0,      0,           0,0,0,0, 0,0,0,0};
    tbl[1]  = '{1,0,'h010,  0,0,0,      0,           1,0,0,0, 0,0,'h010,0};
    tbl[2]  = '{0,0,0,      0,0,0,      'hAAAA0001,  0,0,1,0, 'hAAAA0001,0,0,0};
    tbl[3]  = '{1,1,'h020,  0,0,0,      'h99,        1,0,0,0, 0,0,'h020,1};
    tbl[4]  = '{0,0,0,      0,0,0,      'h1234,      0,0,0,0, 0,0,0,0};
    tbl[5]  = '{1,0,'h004,  0,0,0,      0,           1,0,0,0, 0,0,'h004,0};
    tbl[6]  = '{0,0,0,      1,0,'h008,  'h11111111,  0,1,1,0, 'h11111111,0,'h008,0};
    tbl[7]  = '{0,0,0,      0,0,0,      'h22222222,  0,0,0,1, 0,'h22222222,0,0};
    tbl[8]  = '{1,0,'h030,  1,0,'h040,  'h33,        1,0,0,0, 0,0,'h030,0};
    tbl[9]  = '{1,0,'h030,  1,0,'h040,  'h44,        1,0,1,0, 'h44,0,'h030,0};
    tbl[10] = '{1,0,'h030,  1,0,'h040,  'h55,        1,0,1,0, 'h55,0,'h030,0};
    tbl[11] = '{1,0,'h030,  1,0,'h040,  'h66,        1,0,1,0, 'h66,0,'h030,0};
    tbl[12] = '{1,0,'h030,  1,0,'h040,  'h77,        0,1,1,0, 'h77,0,'h040,0};
    tbl[13] = '{1,0,'h030,  1,0,'h040,  'h88,        1,0,0,1, 0,'h88,'h030,0};
    tbl[14] = '{0,0,0,      0,0,0,      'h99,        0,0,1,0, 'h99,0,0,0};
    tbl[15] = '{1,1,'h050,  1,1,'h060,  'hAB,        1,0,0,0, 0,0,'h050,1};
    tbl[16] = tbl[15];
    tbl[17] = '{1,1,'h050,  0,0,0,      'hAB,        1,0,0,0, 0,0,'h050,1};
    for (int i = 18; i < 22; i++) tbl[i] = tbl[15];
    tbl[22] = '{1,1,'h050,  1,1,'h060,  'hAB,        0,1,0,0, 0,0,'h060,1};
    tbl[23] = tbl[0];

    repeat (2) @(negedge clock);
    #1;
    chk("rst m0_gnt", 32'(m0_gnt), 0);
    chk("rst m1_gnt", 32'(m1_gnt), 0);
    chk("rst rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
    chk("rst ram_wen", 32'(ram_wen), 0);
    chk("rst ram_addr", 32'(ram_addr), 0);
    chk("rst ram_wdata", ram_wdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      m0_req = tbl[i].m0_req; m0_we = tbl[i].m0_we; m0_addr = tbl[i].m0_addr;
      m1_req = tbl[i].m1_req; m1_we = tbl[i].m1_we; m1_addr = tbl[i].m1_addr;
      ram_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(tbl[i].g0));
      chk($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(tbl[i].g1));
      chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].v0));
      chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(tbl[i].v1));
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, tbl[i].d0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, tbl[i].d1);
      chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].ra));
      chk($sformatf("v%0d ram_wen", i), 32'(ram_wen), 32'(tbl[i].wen));
    end
    chk("type passthru", 32'(ram_type), 0);

    // locked burst of 10 writes with m0 held: 4 m0, 8 m1, 1 m0, then m1 finishes
    m0_we = 1; m1_we = 1; m0_addr = 'h200; m1_addr = 'h300; ram_rdata = 0;
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 0, $sformatf("bw%0d", i));
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 1, 0, 1, $sformatf("bst%0d", i));
      chk($sformatf("bst%0d type", i), 32'(ram_type), 5);
      m1_addr = m1_addr + 14'd4;
    end
    cyc(1, 1, 1, 1, 0, "bmax m0");
    chk("bmax type", 32'(ram_type), 2);
    cyc(0, 1, 1, 0, 1, "bres0");
    m1_addr = m1_addr + 14'd4;
    cyc(0, 1, 1, 0, 1, "bres1");
    cyc(0, 1, 0, 0, 0, "bidle");
    // dropping lock ends a burst but that cycle still grants m1
    cyc(0, 1, 1, 0, 1, "lk0");
    cyc(1, 1, 1, 0, 1, "lk1");
    cyc(1, 0, 1, 0, 1, "lkdrop");
    cyc(1, 0, 1, 1, 0, "lkm0");
    cyc(0, 0, 0, 0, 0, "lkidle");

    // quiet bus for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0, $sformatf("idle%0d", i));
      chk($sformatf("idle%0d rvalid", i), 32'({m0_rvalid, m1_rvalid}), 0);
    end

    // reset right after a granted m1 read drops its return
    m1_we = 0; m0_we = 0; m1_addr = 'h044; m0_addr = 'h088; ram_rdata = 32'hDEADBEEF;
    cyc(0, 0, 1, 0, 1, "rd m1");
    @(negedge clock);
    reset = 1; m1_req = 0; m0_req = 1;
    #1;
    chk("mid rst m1_rvalid", 32'(m1_rvalid), 0);
    chk("mid rst m1_rdata", m1_rdata, 0);
    chk("mid rst m0_gnt", 32'(m0_gnt), 0);
    chk("mid rst ram_wen", 32'(ram_wen), 0);
    @(negedge clock);
    #1;
    chk("hold rst m0_gnt", 32'(m0_gnt), 0);
    chk("hold rst m1_rvalid", 32'(m1_rvalid), 0);
    @(negedge clock);
    reset = 0;
    #1;
    chk("post rst m0_gnt", 32'(m0_gnt), 1);
    chk("post rst ram_addr", 32'(ram_addr), 'h088);
    @(negedge clock);
    m0_req = 0;
    #1;
    chk("post rst m0_rvalid", 32'(m0_rvalid), 1);
    chk("post rst m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("post rst m1_rvalid", 32'(m1_rvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
